// File: rtl/sram_dport_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_dport_arbiter
// Purpose  : Shares the single data port of the main SRAM between two
//            native-bus masters (m0 = CPU data bus, m1 = DMA/boot copier).
//            Round-robin arbitration, at most one transaction outstanding,
//            and a new request may issue in the cycle the previous response
//            returns, so alternating masters sustain one transaction/cycle.
// Ports    : clk, rst            - clock, asynchronous active-high reset
//            mN_valid/addr/wdata/wstrb - master N request (wstrb==0 is read),
//                                  held until mN_ready
//            mN_ready/rdata      - master N one-cycle completion, read data
//            s_valid/addr/wdata/wstrb - SRAM issue pulse and request fields
//            s_ready/rdata       - SRAM completion one cycle after s_valid
// Revision : 1.0 - initial release
// ============================================================================
module sram_dport_arbiter #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_valid,
    input  logic [ADDR_W-1:0]     m0_addr,
    input  logic [DATA_W-1:0]     m0_wdata,
    input  logic [DATA_W/8-1:0]   m0_wstrb,
    output logic [DATA_W-1:0]     m0_rdata,
    output logic                  m0_ready,

    input  logic                  m1_valid,
    input  logic [ADDR_W-1:0]     m1_addr,
    input  logic [DATA_W-1:0]     m1_wdata,
    input  logic [DATA_W/8-1:0]   m1_wstrb,
    output logic [DATA_W-1:0]     m1_rdata,
    output logic                  m1_ready,

    output logic                  s_valid,
    output logic [ADDR_W-1:0]     s_addr,
    output logic [DATA_W-1:0]     s_wdata,
    output logic [DATA_W/8-1:0]   s_wstrb,
    input  logic [DATA_W-1:0]     s_rdata,
    input  logic                  s_ready
);

    localparam int c_STRB_W = DATA_W / 8;

    // busy: one transaction outstanding; gnt: its owner; last: last served.
    logic busy_q, busy_d;
    logic gnt_q,  gnt_d;
    logic last_q, last_d;

    logic                w_resp;
    logic                w_slot;
    logic                w_elig0;
    logic                w_elig1;
    logic                w_sel;
    logic                w_issue;
    logic [ADDR_W-1:0]   w_addr_sel;
    logic [DATA_W-1:0]   w_wdata_sel;
    logic [c_STRB_W-1:0] w_wstrb_sel;

    always_comb begin
        // A response only counts while something is outstanding; a stray
        // s_ready in the idle state is ignored.
        w_resp  = busy_q & s_ready;
        w_slot  = ~busy_q | w_resp;
        // The completing master's valid still belongs to the request being
        // answered, so it cannot be re-issued in the same cycle.
        w_elig0 = m0_valid & ~(w_resp & ~gnt_q);
        w_elig1 = m1_valid & ~(w_resp &  gnt_q);
        // On a tie the master that was not served last wins.
        w_sel   = (w_elig0 & w_elig1) ? ~last_q : w_elig1;
        w_issue = ~rst & w_slot & (w_elig0 | w_elig1);

        w_addr_sel  = w_sel ? m1_addr  : m0_addr;
        w_wdata_sel = w_sel ? m1_wdata : m0_wdata;
        w_wstrb_sel = w_sel ? m1_wstrb : m0_wstrb;
    end

    always_comb begin
        busy_d = busy_q;
        gnt_d  = gnt_q;
        last_d = last_q;
        if (w_resp) begin
            last_d = gnt_q;
            busy_d = 1'b0;
        end
        // An issue in the completion cycle keeps the port busy.
        if (w_issue) begin
            busy_d = 1'b1;
            gnt_d  = w_sel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            gnt_q  <= 1'b0;
            last_q <= 1'b1;   // m0 wins the first tie after reset
        end else begin
            busy_q <= busy_d;
            gnt_q  <= gnt_d;
            last_q <= last_d;
        end
    end

    // SRAM request side: fields are forced to zero when nothing issues.
    always_comb begin
        s_valid = w_issue;
        s_addr  = w_issue ? w_addr_sel  : '0;
        s_wdata = w_issue ? w_wdata_sel : '0;
        s_wstrb = w_issue ? w_wstrb_sel : '0;
    end

    // Master response side: only the owner of the returning response sees
    // ready and data; busy_q is held at 0 by reset, which blocks both.
    always_comb begin
        m0_ready = w_resp & ~gnt_q;
        m1_ready = w_resp &  gnt_q;
        m0_rdata = m0_ready ? s_rdata : '0;
        m1_rdata = m1_ready ? s_rdata : '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_dport_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_dport_arbiter
// Purpose  : Self-checking bench for sram_dport_arbiter: table vectors,
//            hand-written multi-cycle sequences and randomized traffic
//            compared against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_dport_arbiter;

    localparam int AW = 13;
    localparam int DW = 32;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_valid, m1_valid;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata;
    logic [SW-1:0] m0_wstrb, m1_wstrb;
    logic          m0_ready, m1_ready;
    logic          s_valid;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic [DW-1:0] s_rdata;
    logic [SW-1:0] s_wstrb;
    logic          s_ready;
    logic          sready_q = 1'b0;
    logic          inj = 1'b0;

    assign s_ready = sready_q | inj;

    sram_dport_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata), .m0_ready(m0_ready),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata), .m1_ready(m1_ready),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_rdata(s_rdata), .s_ready(s_ready)
    );

    always #5 clk = ~clk;

    // ---------------- common helpers ----------------
    function automatic logic [31:0] init_val(input logic [AW-1:0] a);
        if (a == 13'h10) return 32'hDEADBEEF;
        if (a == 13'h40) return 32'h11223344;
        return 32'hC0DE0000 | 32'(a);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] st);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // ---------------- SRAM environment (1-cycle latency) ----------------
    logic [31:0] smem [0:8191];
    bit          swr  [0:8191];

    function automatic logic [31:0] sram_word(input logic [AW-1:0] a);
        return swr[a] ? smem[a] : init_val(a);
    endfunction

    always @(posedge clk) begin
        if (s_valid) begin
            s_rdata  <= sram_word(s_addr);
            sready_q <= 1'b1;
            if (s_wstrb != 4'h0) begin
                smem[s_addr] <= merge(sram_word(s_addr), s_wdata, s_wstrb);
                swr[s_addr]  <= 1'b1;
            end
        end else begin
            s_rdata  <= 32'($urandom);   // garbage when no response
            sready_q <= 1'b0;
        end
    end

    // ---------------- bookkeeping ----------------
    int vecs = 0;
    int errs = 0;

    task automatic chk(input string nm, input logic [63:0] act_v, input logic [63:0] exp_v);
        vecs++;
        if (act_v !== exp_v) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at time %0t", nm, act_v, exp_v, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    typedef struct {
        logic [AW-1:0] a;
        logic [31:0]   d;
        logic [3:0]    s;
    } req_t;

    req_t        q0[$], q1[$];           // per-master pending requests
    bit          pres[2];                 // head currently presented
    bit          seen_r[2];
    bit          out_v;                   // one outstanding transaction
    int          out_own;
    bit          out_rd;
    logic [31:0] out_exp;
    int          last_m;
    logic [31:0] mmem[int];
    int          rdy_log[$];
    bit          iss_log[$];
    logic [31:0] rd0_log[$];

    function automatic logic [31:0] mword(input logic [AW-1:0] a);
        return mmem.exists(int'(a)) ? mmem[int'(a)] : init_val(a);
    endfunction

    function automatic int lg(input int k);
        return (k < rdy_log.size()) ? rdy_log[k] : -2;
    endfunction

    task automatic model_reset();
        out_v  = 1'b0;
        last_m = 1;
        pres[0] = 1'b0;
        pres[1] = 1'b0;
        q0.delete();
        q1.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m0_valid = 1'b1;   // requests during reset must be ignored
        m1_valid = 1'b1;
        m0_addr = 13'h10; m1_addr = 13'h11;
        m0_wdata = '0; m1_wdata = '0; m0_wstrb = '0; m1_wstrb = '0;
        model_reset();
        @(negedge clk);
        chk("rst_s_valid", 64'(s_valid), 64'd0);
        chk("rst_ready", 64'({m0_ready, m1_ready}), 64'd0);
        chk("rst_rdata", {m0_rdata, m1_rdata}, 64'd0);
        @(posedge clk); #1;
        m0_valid = 1'b0;
        m1_valid = 1'b0;
        rst = 1'b0;
    endtask

    task automatic drive(input bit gaps);
        if (!pres[0] && q0.size() > 0 && (!gaps || $urandom_range(0, 2) != 0)) pres[0] = 1'b1;
        if (!pres[1] && q1.size() > 0 && (!gaps || $urandom_range(0, 2) != 0)) pres[1] = 1'b1;
        m0_valid = pres[0];
        m1_valid = pres[1];
        if (pres[0]) begin m0_addr = q0[0].a; m0_wdata = q0[0].d; m0_wstrb = q0[0].s; end
        else begin m0_addr = AW'($urandom); m0_wdata = 32'($urandom); m0_wstrb = SW'($urandom); end
        if (pres[1]) begin m1_addr = q1[0].a; m1_wdata = q1[0].d; m1_wstrb = q1[0].s; end
        else begin m1_addr = AW'($urandom); m1_wdata = 32'($urandom); m1_wstrb = SW'($urandom); end
    endtask

    // Evaluated mid-cycle: predicts this cycle's outputs, then advances.
    task automatic model_cycle();
        int            comp, sel;
        bit            e0, e1;
        logic [AW-1:0] ea;
        logic [31:0]   ed, er;
        logic [3:0]    es;
        comp = (out_v && s_ready) ? out_own : -1;
        e0 = m0_valid && comp != 0;
        e1 = m1_valid && comp != 1;
        if (e0 && e1)  sel = (last_m == 0) ? 1 : 0;
        else if (e0)   sel = 0;
        else if (e1)   sel = 1;
        else           sel = -1;
        ea = '0; ed = '0; es = '0;
        if (sel == 0) begin ea = m0_addr; ed = m0_wdata; es = m0_wstrb; end
        if (sel == 1) begin ea = m1_addr; ed = m1_wdata; es = m1_wstrb; end
        er = out_rd ? out_exp : s_rdata;   // write response data is pass-through
        chk("s_valid", 64'(s_valid), 64'(sel >= 0));
        chk("s_req", 64'({s_addr, s_wdata, s_wstrb}), 64'({ea, ed, es}));
        chk("m_ready", 64'({m0_ready, m1_ready}), 64'({comp == 0, comp == 1}));
        chk("m_rdata", {m0_rdata, m1_rdata},
            {(comp == 0) ? er : 32'h0, (comp == 1) ? er : 32'h0});
        seen_r[0] = m0_ready;
        seen_r[1] = m1_ready;
        rdy_log.push_back(comp);
        iss_log.push_back(sel >= 0);
        if (comp == 0 && out_rd) rd0_log.push_back(m0_rdata);
        if (comp >= 0) begin last_m = comp; out_v = 1'b0; end
        if (sel >= 0) begin
            out_v   = 1'b1;
            out_own = sel;
            out_rd  = (es == 4'h0);
            out_exp = mword(ea);
            if (es != 4'h0) mmem[int'(ea)] = merge(out_exp, ed, es);
        end
    endtask

    task automatic run(input int maxc, input bit gaps, input string nm);
        rdy_log.delete(); iss_log.delete(); rd0_log.delete();
        for (int c = 0; c < maxc; c++) begin
            drive(gaps);
            if (q0.size() == 0 && q1.size() == 0 && !out_v) break;
            @(negedge clk);
            model_cycle();
            @(posedge clk); #1;
            if (seen_r[0] && pres[0]) begin void'(q0.pop_front()); pres[0] = 1'b0; end
            if (seen_r[1] && pres[1]) begin void'(q1.pop_front()); pres[1] = 1'b0; end
        end
        chk({nm, "_drained"}, 64'(q0.size() == 0 && q1.size() == 0), 64'd1);
    endtask

    // ---------------- table vectors (each from reset) ----------------
    typedef struct {
        bit            v0, v1;
        logic [AW-1:0] a0, a1;
        logic [31:0]   d0, d1;
        logic [3:0]    s0, s1;
        bit            exp_sv;
        logic [AW-1:0] exp_a;
        logic [31:0]   exp_d;
        logic [3:0]    exp_s;
        logic [1:0]    exp_r;     // {m0_ready, m1_ready} in the next cycle
        bit            chk_rd;
        logic [31:0]   exp_rd;
    } vec_t;

    vec_t tv[6];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        req_t r;
        bit   ok;
        rst = 1'b1;
        m0_valid = 1'b0; m1_valid = 1'b0;
        m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
        m0_wstrb = '0; m1_wstrb = '0;

        tv[0] = '{1, 0, 13'h10, 13'h00, 32'h0,        32'h0,        4'h0, 4'h0,
                  1, 13'h10, 32'h0,        4'h0, 2'b10, 1, 32'hDEADBEEF};
        tv[1] = '{0, 1, 13'h00, 13'h11, 32'h0,        32'h55,       4'h0, 4'h0,
                  1, 13'h11, 32'h55,       4'h0, 2'b01, 1, 32'hC0DE0011};
        tv[2] = '{1, 1, 13'h12, 13'h13, 32'h0,        32'h0,        4'h0, 4'h0,
                  1, 13'h12, 32'h0,        4'h0, 2'b10, 1, 32'hC0DE0012};
        tv[3] = '{0, 0, 13'h14, 13'h15, 32'h77,       32'h88,       4'h3, 4'h5,
                  0, 13'h00, 32'h0,        4'h0, 2'b00, 1, 32'h0};
        tv[4] = '{0, 1, 13'h00, 13'h30, 32'h0,        32'h12345678, 4'h0, 4'hF,
                  1, 13'h30, 32'h12345678, 4'hF, 2'b01, 0, 32'h0};
        tv[5] = '{1, 1, 13'h31, 13'h13, 32'hCAFEF00D, 32'h0,        4'h3, 4'h0,
                  1, 13'h31, 32'hCAFEF00D, 4'h3, 2'b10, 0, 32'h0};

        for (int i = 0; i < 6; i++) begin
            do_reset();
            m0_valid = tv[i].v0; m0_addr = tv[i].a0; m0_wdata = tv[i].d0; m0_wstrb = tv[i].s0;
            m1_valid = tv[i].v1; m1_addr = tv[i].a1; m1_wdata = tv[i].d1; m1_wstrb = tv[i].s1;
            @(negedge clk);
            chk("tv_s_valid", 64'(s_valid), 64'(tv[i].exp_sv));
            chk("tv_s_req", 64'({s_addr, s_wdata, s_wstrb}),
                64'({tv[i].exp_a, tv[i].exp_d, tv[i].exp_s}));
            @(posedge clk); #1;
            m0_valid = 1'b0; m1_valid = 1'b0;
            @(negedge clk);
            chk("tv_ready", 64'({m0_ready, m1_ready}), 64'(tv[i].exp_r));
            if (tv[i].chk_rd)
                chk("tv_rdata", {m0_rdata, m1_rdata},
                    (tv[i].exp_r == 2'b10) ? {tv[i].exp_rd, 32'h0} :
                    (tv[i].exp_r == 2'b01) ? {32'h0, tv[i].exp_rd} : 64'h0);
            @(posedge clk); #1;
        end

        // Continuous contention: tie goes to m0, then strict alternation.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            r = '{13'h100 + AW'(i), 32'h0, 4'h0}; q0.push_back(r);
            r = '{13'h180 + AW'(i), 32'h0, 4'h0}; q1.push_back(r);
        end
        run(100, 1'b0, "contention");
        chk("tie_first", 64'(lg(1)), 64'(0));
        chk("tie_second", 64'(lg(2)), 64'(1));
        ok = (lg(0) == -1) && (rdy_log.size() == 17);
        for (int k = 1; k <= 16; k++) if (lg(k) != (k - 1) % 2) ok = 1'b0;
        chk("alternation_16_in_16", 64'(ok), 64'd1);

        // Single-master streaming: issue every other cycle.
        for (int i = 0; i < 4; i++) begin
            r = '{AW'(i), 32'hA0 + 32'(i), 4'hF}; q1.push_back(r);
        end
        run(50, 1'b0, "stream");
        ok = (iss_log.size() >= 7);
        for (int k = 0; k < 7 && k < iss_log.size(); k++) if (iss_log[k] != ((k % 2) == 0)) ok = 1'b0;
        chk("stream_gap", 64'(ok), 64'd1);
        for (int i = 0; i < 4; i++) begin
            r = '{AW'(i), 32'h0, 4'h0}; q0.push_back(r);
        end
        run(50, 1'b0, "readback");
        for (int i = 0; i < 4; i++)
            chk("readback", 64'((i < rd0_log.size()) ? rd0_log[i] : 32'hX), 64'(32'hA0 + 32'(i)));

        // Byte write into a preset word, then read it back.
        r = '{13'h40, 32'h00FF0000, 4'h4}; q0.push_back(r);
        r = '{13'h40, 32'h0, 4'h0};        q0.push_back(r);
        run(20, 1'b0, "bytewr");
        chk("byte_write", 64'((rd0_log.size() > 0) ? rd0_log[0] : 32'hX), 64'(32'h11FF3344));

        // Reset while busy; the SRAM response arrives after reset releases.
        do_reset();
        m0_valid = 1'b1; m0_addr = 13'h10; m0_wdata = '0; m0_wstrb = '0;
        @(negedge clk);
        chk("mid_issue", 64'(s_valid), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1; m0_valid = 1'b0;
        #2 rst = 1'b0;
        @(negedge clk);
        chk("mid_late_sready", 64'(s_ready), 64'd1);
        chk("mid_no_ready", 64'({m0_ready, m1_ready, s_valid}), 64'd0);
        @(posedge clk); #1;
        m1_valid = 1'b1; m1_addr = 13'h11; m1_wdata = '0; m1_wstrb = '0;
        @(negedge clk);
        chk("post_rst_issue", 64'({s_valid, s_addr}), 64'({1'b1, 13'h11}));
        @(posedge clk); #1;
        m1_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 64'({m0_ready, m1_ready}), 64'(2'b01));
        chk("post_rst_rdata", 64'(m1_rdata), 64'(32'hC0DE0011));
        @(posedge clk); #1;

        // Spurious s_ready while idle: no ready, no change to tie order.
        do_reset();
        inj = 1'b1;
        @(negedge clk);
        chk("spur_no_ready", 64'({m0_ready, m1_ready, s_valid}), 64'd0);
        @(posedge clk); #1;
        inj = 1'b0;
        m0_valid = 1'b1; m0_addr = 13'h12;
        m1_valid = 1'b1; m1_addr = 13'h13;
        @(negedge clk);
        chk("spur_tie", 64'(s_addr), 64'(13'h12));
        @(posedge clk); #1;
        m0_valid = 1'b0; m1_valid = 1'b0;
        @(negedge clk);
        chk("spur_ready", 64'({m0_ready, m1_ready}), 64'(2'b10));
        chk("spur_rdata", 64'(m0_rdata), 64'(32'hC0DE0012));
        @(posedge clk); #1;

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 120; i++) begin
            r.a = 13'h100 + AW'($urandom_range(0, 15));
            r.d = 32'($urandom);
            r.s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            if ($urandom_range(0, 1) == 0) q0.push_back(r); else q1.push_back(r);
        end
        run(3000, 1'b1, "random");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_dport_arbiter.md
Name: sram_dport_arbiter

Overview:
- Shares the single data port of the main SRAM between two native-bus masters: m0 (CPU data bus) and m1 (DMA/boot copier).
- Arbitration is round-robin with at most one transaction outstanding on the SRAM port.
- The SRAM port is valid/ready with fixed 1-cycle latency. Ready is registered from valid, and rdata is valid in the ready cycle.
- A new request issues in the same cycle the previous response returns, so alternating masters sustain one transaction per cycle.

Parameters:
- ADDR_W, 13: word address width; equals SRAM address width minus 2.
- DATA_W, 32: data width; strobe width is DATA_W/8.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- m0_valid  input  1  master 0 request; held until m0_ready
- m0_addr  input  ADDR_W  master 0 word address
- m0_wdata  input  DATA_W  master 0 write data
- m0_wstrb  input  DATA_W/8  master 0 byte strobes; 0 means read
- m0_rdata  output  DATA_W  master 0 read data; valid only when m0_ready
- m0_ready  output  1  master 0 one-cycle completion pulse
- m1_valid, m1_addr, m1_wdata, m1_wstrb, m1_rdata, m1_ready: same as m0, for master 1
- s_valid  output  1  SRAM port enable, one-cycle issue pulse
- s_addr  output  ADDR_W  SRAM address
- s_wdata  output  DATA_W  SRAM write data
- s_wstrb  output  DATA_W/8  SRAM byte write enables
- s_rdata  input  DATA_W  SRAM read data
- s_ready  input  1  SRAM completion, one cycle after s_valid

Behaviour:
- Registers:
  - busy: one transaction outstanding.
  - gnt: master owning the outstanding transaction.
  - last: last master served.
  - Reset values: busy=0, gnt=0, last=1, so m0 wins the first tie.
- Outputs during reset: s_valid, m0_ready and m1_ready are 0 while rst is high, regardless of m*_valid. m*_rdata is 0.
- Issue slot: exists when busy=0, or when busy=1 and s_ready=1 (response returning this cycle).
- Eligible set:
  - Includes every master with valid=1.
  - Excludes the master whose response returns this cycle; its valid still belongs to the completing request.
- Selection:
  - Both eligible: pick the master that is not last.
  - One eligible: pick it.
- Issue:
  - s_valid=1 combinationally.
  - s_addr, s_wdata, s_wstrb are muxed from the selected master.
  - At the clock edge: busy<=1, gnt<=selected.
- Idle outputs: when no issue occurs, s_valid=0 and s_addr/s_wdata/s_wstrb are driven with 0.
- Completion:
  - When busy=1 and s_ready=1: m<gnt>_ready=1 for that cycle and m<gnt>_rdata=s_rdata.
  - The other master's ready and rdata are 0.
  - last<=gnt. If no new issue happens in the same cycle, busy<=0.
- Latency:
  - Uncontended request: issue in the cycle valid is first seen; ready the next cycle.
  - Contended request: waits at most one extra transaction.
- Fairness: both masters requesting continuously are served strictly alternating, m0,m1,m0,m1..., one completion per cycle.
- Single master requesting back-to-back:
  - The excluded-master rule forces a 1-cycle gap.
  - Throughput is one transaction per 2 cycles.
- Spurious s_ready (busy=0): ignored; no m*_ready, no state change.
- Master rule: a master must not drop valid or change addr/wdata/wstrb before its ready. The arbiter does not check this.
- Asynchronous reset mid-transaction:
  - All registers return to reset values.
  - The outstanding response is discarded.
  - No ready is generated after reset deasserts, even if s_ready arrives.
- Write transactions complete with ready exactly like reads; rdata content is don't-care for writes, but the gating rules still apply.

Test Plan:
- Reset then single read: SRAM preloaded with word 0x10 = 0xDEADBEEF; m0 reads addr 0x10 → s_valid in cycle 0, m0_ready and m0_rdata=0xDEADBEEF in cycle 1, m1_ready=0 throughout.
- Tie: both masters assert valid in the same first cycle after reset → m0 issued first, m1 issued in m0's ready cycle; readies on consecutive cycles m0 then m1.
- Continuous contention: both masters hold requests for 8 transactions each → ready sequence strictly alternates m0,m1,...; 16 completions in 16 cycles after the first issue.
- Single-master streaming: m1 writes addrs 0..3 with wstrb=0xF, data 0xA0..0xA3, back-to-back → s_valid every other cycle; readback via m0 returns 0xA0..0xA3.
- Byte write: m0 writes 0x00FF0000 with wstrb=0x4 to a word holding 0x11223344 → readback 0x11FF3344.
- Reset mid-transaction and spurious s_ready:
  - Reset while busy with s_ready arriving one cycle later → no m*_ready pulse, busy=0 after reset.
  - Injected s_ready while idle → no m*_ready pulse.
